// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle control unit: opcodes, FSM states, datapath mux selects, fault codes.
// Pure definitions; no timing or flow control of its own.
package cpu_pkg;

  localparam logic [3:0] OP_RTYPE = 4'h0;
  localparam logic [3:0] OP_ADDI  = 4'h1;
  localparam logic [3:0] OP_LW    = 4'h2;
  localparam logic [3:0] OP_SW    = 4'h3;
  localparam logic [3:0] OP_BEQ   = 4'h4;
  localparam logic [3:0] OP_BNE   = 4'h5;
  localparam logic [3:0] OP_J     = 4'h6;
  localparam logic [3:0] OP_HALT  = 4'hF;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_WB_R     = 4'd3,
    S_EXEC_I   = 4'd4,
    S_WB_I     = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_WB_MEM   = 4'd8,
    S_MEM_WR   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_HALT     = 4'd12,
    S_FAULT    = 4'd13
  } state_e;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REGB = 2'b00;
  localparam logic [1:0] SRCB_ONE  = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [1:0] {
    FAULT_NONE    = 2'b00,
    FAULT_ILLEGAL = 2'b01,
    FAULT_TIMEOUT = 2'b10
  } fault_e;

  function automatic logic is_wait_state(input state_e s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/multicycle_cu_if.sv
// Control-unit <-> datapath bundle: datapath status in, every control strobe and debug status out.
// master = control unit, slave = datapath side.
interface multicycle_cu_if #(parameter int CNT_W = 16);
  logic [3:0]       opcode;
  logic             Zero;
  logic             mem_ready;
  logic             PCWrite;
  logic             IorD;
  logic             MemRead;
  logic             MemWrite;
  logic             IRWrite;
  logic             RegDst;
  logic             MemToReg;
  logic             RegWrite;
  logic             ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [1:0]       ALUOp;
  logic [1:0]       PCSource;
  logic [3:0]       state;
  logic             halted;
  logic [1:0]       fault;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  opcode, Zero, mem_ready,
    output PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemToReg, RegWrite,
           ALUSrcA, ALUSrcB, ALUOp, PCSource, state, halted, fault, instr_count
  );

  modport slave (
    output opcode, Zero, mem_ready,
    input  PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemToReg, RegWrite,
           ALUSrcA, ALUSrcB, ALUOp, PCSource, state, halted, fault, instr_count
  );
endinterface

// File: rtl/mem_wait_watchdog.sv
// Counts consecutive not-ready cycles of a memory wait state; timeout_o fires combinationally on the
// WAIT_MAX-th stalled cycle. A ready cycle (or leaving the wait state) clears the count.
module mem_wait_watchdog #(
  parameter int WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic wait_i,
  input  logic ready_i,
  output logic timeout_o
);

  localparam int CW = $clog2(WAIT_MAX + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          stall;

  assign stall = wait_i && !ready_i;

  always_comb begin
    cnt_d = '0;
    if (stall) cnt_d = cnt_q + CW'(1);
  end

  // The count lags by one cycle, so the limit is hit while cnt_q still shows WAIT_MAX-1.
  assign timeout_o = stall && (cnt_q == CW'(WAIT_MAX - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/multicycle_cu.sv
// Multi-cycle CPU control FSM: 3-5 cycles per instruction plus memory stall cycles; stalls on mem_ready,
// faults after WAIT_MAX stalled cycles, HALT/FAULT hold until reset.
module multicycle_cu
  import cpu_pkg::*;
#(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 16
) (
  input logic            clk,
  input logic            rst,
  multicycle_cu_if.master bus
);

  state_e     state_q, state_d;
  logic [3:0] opcode_q, opcode_d;
  fault_e     fault_q, fault_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic       retire, timeout;

  logic       pc_write, iord, mem_read, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source;

  mem_wait_watchdog #(.WAIT_MAX(WAIT_MAX)) u_wd (
    .clk       (clk),
    .rst       (rst),
    .wait_i    (is_wait_state(state_q)),
    .ready_i   (bus.mem_ready),
    .timeout_o (timeout)
  );

  always_comb begin
    state_d    = state_q;
    opcode_d   = opcode_q;
    fault_d    = fault_q;
    retire     = 1'b0;
    pc_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REGB;
    alu_op     = ALUOP_ADD;
    pc_source  = PCSRC_ALU;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_ONE;
        ir_write  = bus.mem_ready;
        pc_write  = bus.mem_ready;
        if (timeout) begin
          state_d = S_FAULT;
          fault_d = FAULT_TIMEOUT;
        end else if (bus.mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        opcode_d  = bus.opcode;
        alu_src_b = SRCB_BOFF;
        case (bus.opcode)
          OP_RTYPE:      state_d = S_EXEC_R;
          OP_ADDI:       state_d = S_EXEC_I;
          OP_LW, OP_SW:  state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_J:          state_d = S_JUMP;
          OP_HALT:       state_d = S_HALT;
          default: begin
            state_d = S_FAULT;
            fault_d = FAULT_ILLEGAL;
          end
        endcase
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
        state_d   = S_WB_R;
      end
      S_WB_R: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        state_d   = S_FETCH;
        retire    = 1'b1;
      end
      S_EXEC_I, S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        if (state_q == S_EXEC_I)   state_d = S_WB_I;
        else if (opcode_q == OP_LW) state_d = S_MEM_RD;
        else                        state_d = S_MEM_WR;
      end
      S_WB_I: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
        retire    = 1'b1;
      end
      S_MEM_RD, S_MEM_WR: begin
        iord      = 1'b1;
        mem_read  = (state_q == S_MEM_RD);
        mem_write = (state_q == S_MEM_WR);
        if (timeout) begin
          state_d = S_FAULT;
          fault_d = FAULT_TIMEOUT;
        end else if (bus.mem_ready) begin
          state_d = (state_q == S_MEM_RD) ? S_WB_MEM : S_FETCH;
          retire  = (state_q == S_MEM_WR);
        end
      end
      S_WB_MEM: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
        retire     = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_SUB;
        pc_source = PCSRC_ALUOUT;
        pc_write  = ((opcode_q == OP_BEQ) && bus.Zero) || ((opcode_q == OP_BNE) && !bus.Zero);
        state_d   = S_FETCH;
        retire    = 1'b1;
      end
      S_JUMP: begin
        pc_source = PCSRC_JUMP;
        pc_write  = 1'b1;
        state_d   = S_FETCH;
        retire    = 1'b1;
      end
      S_HALT, S_FAULT: state_d = state_q;
      default:         state_d = S_FETCH;
    endcase
    count_d = retire ? count_q + CNT_W'(1) : count_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_FETCH;
      opcode_q <= 4'h0;
      fault_q  <= FAULT_NONE;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      fault_q  <= fault_d;
      count_q  <= count_d;
    end
  end

  // Reset gates strobes combinationally so an in-flight access drops in the same cycle.
  assign bus.PCWrite     = pc_write   & ~rst;
  assign bus.IorD        = iord       & ~rst;
  assign bus.MemRead     = mem_read   & ~rst;
  assign bus.MemWrite    = mem_write  & ~rst;
  assign bus.IRWrite     = ir_write   & ~rst;
  assign bus.RegDst      = reg_dst    & ~rst;
  assign bus.MemToReg    = mem_to_reg & ~rst;
  assign bus.RegWrite    = reg_write  & ~rst;
  assign bus.ALUSrcA     = alu_src_a  & ~rst;
  assign bus.ALUSrcB     = rst ? 2'b00 : alu_src_b;
  assign bus.ALUOp       = rst ? 2'b00 : alu_op;
  assign bus.PCSource    = rst ? 2'b00 : pc_source;
  assign bus.state       = state_q;
  assign bus.halted      = (state_q == S_HALT);
  assign bus.fault       = fault_q;
  assign bus.instr_count = count_q;

endmodule

// File: doc/multicycle_cu.md
Name: multicycle_cu

Overview:
- Multi-cycle control FSM that sequences the 16-bit datapath over FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK states.
- Adds a variable-latency memory handshake, a memory-wait watchdog, a retired-instruction counter and sticky HALT/FAULT states.
- Sits beside the Datapath in CPU and drives all of its control lines. Datapath returns opcode, Zero and mem_ready.

Parameters:
- WAIT_MAX, 15: maximum cycles MemRead/MemWrite may wait for mem_ready before timeout fault (1..255).
- CNT_W, 16: width of retired-instruction counter.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- opcode  in  4  IR[15:12] from Datapath.
- Zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes current access this cycle.
- PCWrite  out  1  PC load enable, unconditional and branch-qualified combined.
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- IRWrite  out  1  instruction register load.
- RegDst  out  1  write register select: 0 = rt, 1 = rd.
- MemToReg  out  1  write data select: 0 = ALUOut, 1 = MDR.
- RegWrite  out  1  register file write.
- ALUSrcA  out  1  0 = PC, 1 = regA.
- ALUSrcB  out  2  00 = regB, 01 = const 1, 10 = sign-ext imm, 11 = sign-ext branch offset.
- ALUOp  out  2  00 = add, 01 = sub, 10 = funct-decoded.
- PCSource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- state  out  4  current state encoding (debug).
- halted  out  1  HALT reached (sticky).
- fault  out  2  00 = none, 01 = illegal opcode, 10 = memory timeout (sticky).
- instr_count  out  CNT_W  retired instructions.

Behaviour:
- Opcodes: 0000 R-type, 0001 ADDI, 0010 LW, 0011 SW, 0100 BEQ, 0101 BNE, 0110 J, 1111 HALT. All others are illegal.
- Reset asserted: state = FETCH, every control output 0, halted = 0, fault = 00, instr_count = 0, wait counter = 0. Outputs are gated to 0 while Reset is high.
- Control outputs are combinational from state, latched opcode, Zero and mem_ready.
- FETCH: IorD = 0, MemRead = 1, ALUSrcA = 0, ALUSrcB = 01, ALUOp = 00, PCSource = 00.
  - IRWrite and PCWrite = mem_ready.
  - Stays in FETCH until mem_ready; then -> DECODE.
- DECODE: opcode is latched into an internal register. ALUSrcA = 0, ALUSrcB = 11, ALUOp = 00 (branch target into ALUOut). Next state by opcode:
  - R-type -> EXEC_R.
  - ADDI -> EXEC_I.
  - LW/SW -> MEM_ADDR.
  - BEQ/BNE -> BRANCH.
  - J -> JUMP.
  - HALT -> HALT.
  - illegal -> FAULT, with fault = 01.
- EXEC_R: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 10 -> WB_R.
- WB_R: RegDst = 1, MemToReg = 0, RegWrite = 1 -> FETCH (retire).
- EXEC_I: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00 -> WB_I.
- WB_I: RegDst = 0, MemToReg = 0, RegWrite = 1 -> FETCH (retire).
- MEM_ADDR: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00. LW -> MEM_RD; SW -> MEM_WR.
- MEM_RD: IorD = 1, MemRead = 1. Waits for mem_ready, then -> WB_MEM.
- WB_MEM: RegDst = 0, MemToReg = 1, RegWrite = 1 -> FETCH (retire).
- MEM_WR: IorD = 1, MemWrite = 1. Waits for mem_ready, then -> FETCH (retire).
- BRANCH: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 01, PCSource = 01.
  - PCWrite = (BEQ & Zero) | (BNE & ~Zero).
  - -> FETCH (retire).
- JUMP: PCSource = 10, PCWrite = 1 -> FETCH (retire).
- Latency (mem_ready always 1): R/ADDI 4 cycles, LW 5, SW 4, BEQ/BNE/J 3.
- Retire: instr_count increments by 1 on every transition into FETCH from a completing state. It wraps modulo 2^CNT_W.
- Watchdog:
  - Wait counter clears on entry to FETCH, MEM_RD and MEM_WR, and counts each waiting cycle with mem_ready = 0.
  - If it reaches WAIT_MAX with mem_ready still 0 -> FAULT, fault = 10.
  - mem_ready arriving on the same cycle the limit is reached wins: no fault.
- HALT and FAULT are absorbing:
  - All control outputs 0, PC frozen.
  - halted = 1 in HALT.
  - fault is held.
  - Only Reset exits.
- Reset mid-access: all outputs drop immediately (asynchronous). FSM restarts at FETCH; the in-flight instruction is not counted.
- mem_ready outside a wait state is ignored.

Decomposition:
- Shared package cpu_pkg:
  - opcode constants.
  - state encoding constants (4-bit).
  - ALUOp, ALUSrcB and PCSource encodings.
  - fault codes.
- One natural sub-module: mem_wait_watchdog, containing the counter, clear/enable logic and WAIT_MAX compare, with a timeout output.

Test Plan:
- Reset, then opcode 0000 with mem_ready = 1 -> states FETCH, DECODE, EXEC_R, WB_R. RegWrite = 1 with RegDst = 1 in cycle 4. instr_count = 1.
- LW (0010) with mem_ready low 3 cycles in FETCH and 2 in MEM_RD -> IRWrite/PCWrite pulse only on ready cycle. WB_MEM asserts MemToReg = 1, RegWrite = 1. Total 10 cycles, instr_count +1.
- BEQ with Zero = 1 -> PCWrite = 1, PCSource = 01 in BRANCH. BNE with Zero = 1 -> PCWrite = 0 in BRANCH. Both retire.
- Opcode 1010 -> FAULT after DECODE, fault = 01, all controls 0 for 20 cycles. Reset -> FETCH, fault = 00.
- WAIT_MAX = 15, mem_ready held 0 in MEM_WR -> fault = 10 after 15 wait cycles. Repeat with mem_ready on cycle 15 -> no fault, SW retires.
- HALT (1111) -> halted = 1 and sticky. Preset instr_count = 0xFFFF, then retire one instruction -> 0x0000. Assert Reset mid-FETCH -> MemRead drops same cycle.
